led_shift_driver: RTL and testbench
===================================

LED_SHIFT_DRIVER -- requirements
Module: led_shift_driver

Interface
REQ-001 Parameter NUM_LED, default 16, shall set the number of LED outputs (range 2..32).
REQ-002 Parameter TICK_DIV, default 1, shall set the clock cycles per LED step (range 1..2^24).
REQ-003 Port clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 Port led_bhv  input  2  shall select the behaviour code: 0 = turn off highest lit LED; 1 = light next LED; 2 = hold; 3 = clear all.
REQ-006 Port led  output  NUM_LED  shall be the LED vector, thermometer-coded from bit 0 upward.
REQ-007 Port lit_cnt  output  clog2(NUM_LED+1) (5 at default)  shall be the number of lit LEDs.
REQ-008 Port full  output  1  shall be high when lit_cnt == NUM_LED.
REQ-009 Port empty  output  1  shall be high when lit_cnt == 0.
REQ-010 Port step  output  1  shall be a one-cycle pulse marking a cycle in which led/lit_cnt took a new value from a step.
REQ-011 Port sat  output  1  shall be a one-cycle pulse marking a step request that was blocked (code 1 while full, code 0 while empty).

Function
REQ-012 Prescaler: counter pcnt, 0..TICK_DIV-1; a step tick occurs when pcnt == TICK_DIV-1 and led_bhv is 0 or 1; pcnt then wraps to 0.
REQ-013 Prescaler restart: pcnt shall load 0 in any cycle where led_bhv differs from its registered previous value bhv_q, or where led_bhv is 2 or 3; there is no tick in such a cycle unless TICK_DIV == 1.
REQ-014 With TICK_DIV == 1, a tick shall occur every cycle in which led_bhv is 0 or 1, including the first cycle after a code change.
REQ-015 Code 3: led <= 0 and lit_cnt <= 0 at the next edge, independent of the tick; step and sat stay low.
REQ-016 Code 2: led, lit_cnt hold; step and sat stay low.
REQ-017 Code 1 on tick, not full: led <= {led[NUM_LED-2:0],1'b1}; lit_cnt <= lit_cnt+1; step = 1 in the cycle after the edge.
REQ-018 Code 1 on tick, full: led and lit_cnt hold; sat = 1 in the cycle after the edge; step = 0.
REQ-019 Code 0 on tick, not empty: led <= {1'b0,led[NUM_LED-1:1]}; lit_cnt <= lit_cnt-1; step = 1 in the cycle after the edge.
REQ-020 Code 0 on tick, empty: led and lit_cnt hold; sat = 1 in the cycle after the edge; step = 0.
REQ-021 step, sat, led and lit_cnt shall all be registered; step and sat shall never be high in the same cycle.
REQ-022 full and empty shall be decoded combinationally from registered lit_cnt and shall never both be high.
REQ-023 Invariant: led shall always equal (2^lit_cnt)-1; lit_cnt shall never exceed NUM_LED or wrap below 0.
REQ-024 The code change itself shall not alter led; only a later tick or code 3 shall change it.

Reset
REQ-025 While rst_n is low, led = 0, lit_cnt = 0, pcnt = 0, bhv_q = 3, step = 0 and sat = 0, asynchronously.
REQ-026 Reset asserted mid-step shall discard the pending step; after release, outputs and counters restart from the REQ-025 values.
REQ-027 The first tick after reset release shall occur no earlier than TICK_DIV edges after the first edge with rst_n high and led_bhv in {0,1}.

Verification
REQ-028 Defaults; reset, then led_bhv = 1 for 20 cycles -> led steps 0x0001, 0x0003 ... 0xFFFF over 16 cycles; step high 16 cycles; full then; sat pulses in the remaining 4 cycles.
REQ-029 From led = 0xFFFF, led_bhv = 0 for 11 cycles -> led = 0x001F, lit_cnt = 5, 11 step pulses; then led_bhv = 3 for 1 cycle -> led = 0, empty = 1.
REQ-030 TICK_DIV = 4; led_bhv = 1 held -> led changes every 4th cycle; toggle led_bhv 1->2->1 mid-count -> next step exactly 4 cycles after returning to 1.
REQ-031 Empty, led_bhv = 0 for 3 cycles -> led stays 0; sat pulses 3 times; step stays 0; lit_cnt stays 0.
REQ-032 led = 0x00FF and led_bhv = 1; rst_n pulsed low asynchronously between edges -> led = 0 immediately; step = 0; after release, the first step gives led = 0x0001.
REQ-033 Random led_bhv over 10k cycles, NUM_LED = 16 and 5 -> the REQ-023 invariant and full/empty exclusivity are never violated.

Source files
------------

// File: rtl/led_shift_driver.sv
// ---------------------------------------------------------------------------
// led_shift_driver
//   Thermometer-coded LED bar driver. A prescaler produces step ticks every
//   TICK_DIV cycles while a stepping behaviour (0 = shrink, 1 = grow) is
//   selected; each tick grows or shrinks the lit bar by one LED. Code 2 holds
//   the bar, code 3 clears it at the next edge.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   led_bhv  : behaviour code (0 shrink, 1 grow, 2 hold, 3 clear)
//   led      : LED vector, lit from bit 0 upward
//   lit_cnt  : number of lit LEDs
//   full     : lit_cnt == NUM_LED
//   empty    : lit_cnt == 0
//   step     : one-cycle pulse, led/lit_cnt just changed because of a tick
//   sat      : one-cycle pulse, a tick was blocked at full/empty
// ---------------------------------------------------------------------------
module led_shift_driver #(
  parameter int NUM_LED  = 16,
  parameter int TICK_DIV = 1,
  localparam int CW      = $clog2(NUM_LED + 1),
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         led_bhv,
  output logic [NUM_LED-1:0] led,
  output logic [CW-1:0]      lit_cnt,
  output logic               full,
  output logic               empty,
  output logic               step,
  output logic               sat
);

  localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_LED);

  logic [NUM_LED-1:0] led_reg;
  logic [CW-1:0]      lit_cnt_reg;
  logic [PW-1:0]      pcnt_reg;
  logic [PW-1:0]      pcnt_next;
  logic [1:0]         bhv_q_reg;
  logic               step_reg;
  logic               sat_reg;
  logic               restart;
  logic               tick;
  logic               full_int;
  logic               empty_int;

  assign full_int  = (lit_cnt_reg == CNT_MAX);
  assign empty_int = (lit_cnt_reg == '0);

  // The prescaler restarts whenever the behaviour changes or a non-stepping
  // code is selected, so a stepping phase always begins with a full period.
  // With TICK_DIV == 1 the period is a single cycle, so even the restart
  // cycle itself ticks.
  always_comb begin
    restart = (led_bhv != bhv_q_reg) || led_bhv[1];
    tick    = 1'b0;
    if (!led_bhv[1]) begin
      if (TICK_DIV == 1)
        tick = 1'b1;
      else
        tick = !restart && (pcnt_reg == PCNT_MAX);
    end
    if (restart || tick)
      pcnt_next = '0;
    else
      pcnt_next = pcnt_reg + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg     <= '0;
      lit_cnt_reg <= '0;
      pcnt_reg    <= '0;
      bhv_q_reg   <= 2'd3;
      step_reg    <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      bhv_q_reg <= led_bhv;
      pcnt_reg  <= pcnt_next;
      step_reg  <= 1'b0;
      sat_reg   <= 1'b0;
      if (led_bhv == 2'd3) begin
        led_reg     <= '0;
        lit_cnt_reg <= '0;
      end else if (tick) begin
        if (led_bhv[0]) begin
          // grow: shift a one in from the bottom
          if (full_int) begin
            sat_reg <= 1'b1;
          end else begin
            led_reg     <= {led_reg[NUM_LED-2:0], 1'b1};
            lit_cnt_reg <= lit_cnt_reg + CW'(1);
            step_reg    <= 1'b1;
          end
        end else begin
          // shrink: drop the highest lit LED
          if (empty_int) begin
            sat_reg <= 1'b1;
          end else begin
            led_reg     <= {1'b0, led_reg[NUM_LED-1:1]};
            lit_cnt_reg <= lit_cnt_reg - CW'(1);
            step_reg    <= 1'b1;
          end
        end
      end
    end
  end

  assign led     = led_reg;
  assign lit_cnt = lit_cnt_reg;
  assign full    = full_int;
  assign empty   = empty_int;
  assign step    = step_reg;
  assign sat     = sat_reg;

endmodule

// File: tb/tb_led_shift_driver.sv
// ---------------------------------------------------------------------------
// tb_led_shift_driver
//   Directed checks of led_shift_driver in three configurations:
//   dut_a (16 LEDs, TICK_DIV 1), dut_b (16 LEDs, TICK_DIV 4),
//   dut_c (5 LEDs, TICK_DIV 1), followed by a random-code run on a and c
//   against a small counting model.
// ---------------------------------------------------------------------------
module tb_led_shift_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bhv_a, bhv_b, bhv_c;

  logic [15:0] led_a, led_b;
  logic [4:0]  led_c;
  logic [4:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;
  logic        full_a, empty_a, step_a, sat_a;
  logic        full_b, empty_b, step_b, sat_b;
  logic        full_c, empty_c, step_c, sat_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_shift_driver #(.NUM_LED(16), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .led_bhv(bhv_a), .led(led_a), .lit_cnt(cnt_a),
    .full(full_a), .empty(empty_a), .step(step_a), .sat(sat_a));

  led_shift_driver #(.NUM_LED(16), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .led_bhv(bhv_b), .led(led_b), .lit_cnt(cnt_b),
    .full(full_b), .empty(empty_b), .step(step_b), .sat(sat_b));

  led_shift_driver #(.NUM_LED(5), .TICK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .led_bhv(bhv_c), .led(led_c), .lit_cnt(cnt_c),
    .full(full_c), .empty(empty_c), .step(step_c), .sat(sat_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [15:0] eled, input int ecnt,
                         input logic estep, input logic esat);
    check({tag, " led"},   32'(led_a),  32'(eled));
    check({tag, " cnt"},   32'(cnt_a),  32'(ecnt));
    check({tag, " step"},  32'(step_a), 32'(estep));
    check({tag, " sat"},   32'(sat_a),  32'(esat));
    check({tag, " full"},  32'(full_a), 32'(ecnt == 16));
    check({tag, " empty"}, 32'(empty_a), 32'(ecnt == 0));
    $display("%-14s led=%04h cnt=%0d step=%0d sat=%0d full=%0d empty=%0d",
             tag, led_a, cnt_a, step_a, sat_a, full_a, empty_a);
  endtask

  int ma, mc;
  logic exp_step_a, exp_sat_a, exp_step_c, exp_sat_c;

  initial begin
    rst_n = 1'b1;
    bhv_a = 2'd3; bhv_b = 2'd3; bhv_c = 2'd3;
    #1 rst_n = 1'b0;
    #2;
    // asynchronous reset before any clock edge
    check_a("reset", 16'h0000, 0, 1'b0, 1'b0);
    check("reset b led", 32'(led_b), 32'h0);
    check("reset c led", 32'(led_c), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check_a("idle", 16'h0000, 0, 1'b0, 1'b0);

    // grow for 20 cycles: 16 steps then 4 saturations
    bhv_a = 2'd1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i <= 16) check_a($sformatf("grow%0d", i), 16'((32'd1 << i) - 1), i, 1'b1, 1'b0);
      else         check_a($sformatf("grow%0d", i), 16'hFFFF, 16, 1'b0, 1'b1);
    end

    // shrink for 11 cycles
    bhv_a = 2'd0;
    for (int i = 1; i <= 11; i++) begin
      cyc();
      check_a($sformatf("shrink%0d", i), 16'(32'hFFFF >> i), 16 - i, 1'b1, 1'b0);
    end
    check("shrink end led", 32'(led_a), 32'h001F);

    // clear
    bhv_a = 2'd3;
    cyc();
    check_a("clear", 16'h0000, 0, 1'b0, 1'b0);

    // shrink while empty: saturates every cycle
    bhv_a = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_a($sformatf("emptysat%0d", i), 16'h0000, 0, 1'b0, 1'b1);
    end

    // grow 3, hold 3, grow 5 more
    bhv_a = 2'd1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_a($sformatf("pregrow%0d", i), 16'((32'd1 << i) - 1), i, 1'b1, 1'b0);
    end
    bhv_a = 2'd2;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_a($sformatf("hold%0d", i), 16'h0007, 3, 1'b0, 1'b0);
    end
    bhv_a = 2'd1;
    for (int i = 4; i <= 8; i++) begin
      cyc();
      check_a($sformatf("regrow%0d", i), 16'((32'd1 << i) - 1), i, 1'b1, 1'b0);
    end

    // asynchronous reset between edges while growing
    #3 rst_n = 1'b0;
    #1;
    check_a("midreset", 16'h0000, 0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cyc();
    check_a("postreset", 16'h0001, 1, 1'b1, 1'b0);
    bhv_a = 2'd3;
    cyc();
    check_a("clear2", 16'h0000, 0, 1'b0, 1'b0);

    // TICK_DIV = 4: first step on the 5th edge (restart edge + 4)
    bhv_b = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("div wait%0d step", i), 32'(step_b), 32'h0);
      check($sformatf("div wait%0d led", i), 32'(led_b), 32'h0);
    end
    cyc();
    check("div step1 step", 32'(step_b), 32'h1);
    check("div step1 led", 32'(led_b), 32'h1);
    $display("div step1      led=%04h step=%0d", led_b, step_b);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check($sformatf("div gap%0d step", i), 32'(step_b), 32'h0);
      check($sformatf("div gap%0d led", i), 32'(led_b), 32'h1);
    end
    cyc();
    check("div step2 step", 32'(step_b), 32'h1);
    check("div step2 led", 32'(led_b), 32'h3);
    $display("div step2      led=%04h step=%0d", led_b, step_b);
    cyc();                          // prescaler mid-count
    bhv_b = 2'd2;
    cyc();
    check("div hold led", 32'(led_b), 32'h3);
    bhv_b = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("div rewait%0d step", i), 32'(step_b), 32'h0);
      check($sformatf("div rewait%0d led", i), 32'(led_b), 32'h3);
    end
    cyc();
    check("div step3 step", 32'(step_b), 32'h1);
    check("div step3 led", 32'(led_b), 32'h7);
    $display("div step3      led=%04h step=%0d", led_b, step_b);
    bhv_b = 2'd3;

    // random codes, compared with a counting model
    ma = 0; mc = 0;
    for (int i = 0; i < 10000; i++) begin
      bhv_a = 2'($urandom_range(0, 3));
      bhv_c = 2'($urandom_range(0, 3));
      if (bhv_a == 2'd3 && $urandom_range(0, 3) != 0) bhv_a = 2'd1;
      exp_step_a = 1'b0; exp_sat_a = 1'b0;
      case (bhv_a)
        2'd3: ma = 0;
        2'd1: if (ma == 16) exp_sat_a = 1'b1; else begin ma++; exp_step_a = 1'b1; end
        2'd0: if (ma == 0)  exp_sat_a = 1'b1; else begin ma--; exp_step_a = 1'b1; end
        default: ;
      endcase
      exp_step_c = 1'b0; exp_sat_c = 1'b0;
      case (bhv_c)
        2'd3: mc = 0;
        2'd1: if (mc == 5) exp_sat_c = 1'b1; else begin mc++; exp_step_c = 1'b1; end
        2'd0: if (mc == 0) exp_sat_c = 1'b1; else begin mc--; exp_step_c = 1'b1; end
        default: ;
      endcase
      cyc();
      check("rnd a led",  32'(led_a),  (32'd1 << ma) - 1);
      check("rnd a cnt",  32'(cnt_a),  32'(ma));
      check("rnd a step", 32'(step_a), 32'(exp_step_a));
      check("rnd a sat",  32'(sat_a),  32'(exp_sat_a));
      check("rnd a fe",   32'({full_a, empty_a}), 32'({ma == 16, ma == 0}));
      check("rnd c led",  32'(led_c),  (32'd1 << mc) - 1);
      check("rnd c cnt",  32'(cnt_c),  32'(mc));
      check("rnd c step", 32'(step_c), 32'(exp_step_c));
      check("rnd c sat",  32'(sat_c),  32'(exp_sat_c));
      check("rnd c fe",   32'({full_c, empty_c}), 32'({mc == 5, mc == 0}));
      if (i % 1000 == 999)
        $display("rnd %5d      a: led=%04h cnt=%0d  c: led=%02h cnt=%0d",
                 i + 1, led_a, cnt_a, led_c, cnt_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
